// File: rtl/alu_seq_fsm.sv
// Sequenced ALU: on an accepted start it captures two operands and a mask of
// up to eight operations, then runs the enabled operations in ascending index
// order, one per clock. Each executed operation produces a registered result,
// flag and op index, qualified by a one-cycle valid pulse. A one-cycle done
// pulse marks the end of the sequence.
module alu_seq_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       op_mask,
  input  logic             accum,
  output logic [WIDTH-1:0] R,
  output logic             flag,
  output logic [2:0]       op_id,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [7:0]       mask_q;
  logic             accum_q;
  logic [2:0]       ptr;

  logic [WIDTH-1:0] alu_r;
  logic             alu_f;
  logic [3:0]       first_idx;
  logic [3:0]       next_idx;

  // Lowest set bit of m at index >= from; returns 8 (bit 3 set) when none.
  function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] res;
    res = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) res = 4'(i);
    end
    return res;
  endfunction

  // Skipping disabled ops is purely combinational, so no cycle is spent on them.
  always_comb begin
    first_idx = find_from(op_mask, 4'd0);
    next_idx  = find_from(mask_q, {1'b0, ptr} + 4'd1);
  end

  // Result and flag of the operation selected by the pointer.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // a value unassigned and infer a latch.
    alu_r = '0;
    alu_f = 1'b0;
    case (op_t'(ptr))
      OP_ADD: {alu_f, alu_r} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        alu_r = a_q - b_q;
        alu_f = (a_q < b_q);
      end
      OP_AND: alu_r = a_q & b_q;
      OP_OR:  alu_r = a_q | b_q;
      OP_XOR: alu_r = a_q ^ b_q;
      OP_NOT: alu_r = ~a_q;
      OP_SHL: begin
        alu_r = {a_q[WIDTH-2:0], 1'b0};
        alu_f = a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_r = {1'b0, a_q[WIDTH-1:1]};
        alu_f = a_q[0];
      end
      default: ;
    endcase
    if (ptr inside {3'd2, 3'd3, 3'd4, 3'd5}) alu_f = (alu_r == '0);
  end

  // Sequencer FSM with registered outputs; DONE lasts two cycles: the first
  // waits for the done pulse, the second carries it while busy stays high.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      accum_q <= 1'b0;
      ptr     <= '0;
      R       <= '0;
      flag    <= 1'b0;
      op_id   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            mask_q  <= op_mask;
            accum_q <= accum;
            ptr     <= first_idx[2:0];
            busy    <= 1'b1;
            state   <= first_idx[3] ? DONE : EXEC;
          end
        end
        EXEC: begin
          R     <= alu_r;
          flag  <= alu_f;
          op_id <= ptr;
          valid <= 1'b1;
          if (accum_q) a_q <= alu_r;
          if (next_idx[3]) state <= DONE;
          else             ptr   <= next_idx[2:0];
        end
        DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Bench for alu_seq_fsm at WIDTH=5: a table of sequences with expected valid
// count and final result, a scoreboard checking every valid pulse against an
// arithmetic reference model, and hand-written busy/reset corner sequences.
module tb_alu_seq_fsm;

  localparam int W    = 5;
  localparam int MAXV = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [7:0]   op_mask;
  logic         accum;
  logic [W-1:0] R;
  logic         flag;
  logic [2:0]   op_id;
  logic         valid;
  logic         busy;
  logic         done;

  alu_seq_fsm #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .op_mask(op_mask), .accum(accum), .R(R), .flag(flag),
    .op_id(op_id), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int r;
    int f;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [7:0]   mask;
    logic         accum;
    int           n;
    int           r;
    int           f;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   nvalid_total = 0;
  int   done_cnt = 0;
  int   last_r = 0;
  int   last_f = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Arithmetic reference for one operation on W-bit unsigned values.
  function automatic void model_op(input int op, input int av, input int bv,
                                   output int r, output int f);
    int s;
    r = 0;
    f = 0;
    case (op)
      0: begin s = av + bv; r = s % MAXV; f = (s >= MAXV) ? 1 : 0; end
      1: begin r = (av - bv + MAXV) % MAXV; f = (av < bv) ? 1 : 0; end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = (MAXV - 1) - av;
      6: begin r = (av * 2) % MAXV; f = (av >= MAXV / 2) ? 1 : 0; end
      7: begin r = av / 2; f = av % 2; end
      default: ;
    endcase
    if (op >= 2 && op <= 5) f = (r == 0) ? 1 : 0;
  endfunction

  task automatic push_model(input int av, input int bv, input logic [7:0] m, input logic acc);
    exp_t e;
    int   r, f;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        model_op(i, av, bv, r, f);
        e.op = i; e.r = r; e.f = f;
        sb.push_back(e);
        if (acc) av = r;
      end
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the next expected op.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("op_id", int'(op_id), e.op);
        check("R", int'(R), e.r);
        check("flag", int'(flag), e.f);
      end
      nvalid_total++;
      last_r = int'(R);
      last_f = int'(flag);
    end
    if (!reset && done) done_cnt++;
  end

  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [7:0] m, input logic acc);
    a = av; b = bv; op_mask = m; accum = acc; start = 1'b1;
  endtask

  task automatic scramble_inputs();
    a = W'($urandom); b = W'($urandom); op_mask = 8'($urandom); accum = 1'($urandom);
  endtask

  // Full sequence with latency, count, final-result and busy-release checks.
  task automatic run_seq(input vec_t v, input bit chk_last);
    int cyc;
    int base;
    @(negedge clk);
    #1;
    base = nvalid_total;
    push_model(int'(v.a), int'(v.b), v.mask, v.accum);
    drive_start(v.a, v.b, v.mask, v.accum);
    @(negedge clk);
    cyc = 1;
    start = 1'b0;
    scramble_inputs();
    check("busy_after_capture", int'(busy), 1);
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done_latency", cyc, v.n + 2);
    check("busy_in_done", int'(busy), 1);
    check("valid_in_done", int'(valid), 0);
    #1;
    check("valid_count", nvalid_total - base, v.n);
    if (chk_last) begin
      check("last_R", last_r, v.r);
      check("last_flag", last_f, v.f);
    end
    check("sb_drained", sb.size(), 0);
    @(negedge clk);
    check("busy_released", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_R"}, int'(R), 0);
    check({tag, "_flag"}, int'(flag), 0);
    check({tag, "_op_id"}, int'(op_id), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  vec_t vecs[$];

  initial begin
    int   base;
    int   dbase;
    int   cyc;
    vec_t v;

    //          a          b          mask   acc   n  r   f
    vecs.push_back('{5'd20,    5'd15,    8'h03, 1'b0, 2, 5,  0});
    vecs.push_back('{5'd10,    5'd3,     8'h03, 1'b1, 2, 10, 0});
    vecs.push_back('{5'b10011, 5'd0,     8'hC0, 1'b0, 2, 9,  1});
    vecs.push_back('{5'b01010, 5'b01010, 8'h14, 1'b0, 2, 0,  1});
    vecs.push_back('{5'd31,    5'd0,     8'h20, 1'b0, 1, 0,  1});
    vecs.push_back('{5'd0,     5'd0,     8'h00, 1'b0, 0, 0,  0});
    vecs.push_back('{5'd31,    5'd1,     8'h01, 1'b0, 1, 0,  1});
    vecs.push_back('{5'd0,     5'd1,     8'h02, 1'b0, 1, 31, 1});
    vecs.push_back('{5'd7,     5'd3,     8'hFF, 1'b1, 8, 15, 0});

    reset = 1'b1;
    start = 1'b0;
    a = '0; b = '0; op_mask = '0; accum = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    foreach (vecs[i]) run_seq(vecs[i], vecs[i].n != 0);

    // A few random sequences checked by the scoreboard alone.
    for (int i = 0; i < 6; i++) begin
      v.a = W'($urandom); v.b = W'($urandom); v.mask = 8'($urandom);
      v.accum = 1'($urandom); v.n = $countones(v.mask); v.r = 0; v.f = 0;
      run_seq(v, 1'b0);
    end

    // start pulsed during EXEC and in the done cycle must be ignored.
    @(negedge clk);
    #1;
    base  = nvalid_total;
    dbase = done_cnt;
    push_model(9, 6, 8'hFF, 1'b0);
    drive_start(5'd9, 5'd6, 8'hFF, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    drive_start(5'd1, 5'd2, 8'h01, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("exec_done_seen", int'(done), 1);
    drive_start(5'd3, 5'd3, 8'h01, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", int'(busy), 0);
    repeat (3) @(negedge clk);
    #1;
    check("ignored_start_valids", nvalid_total - base, 8);
    check("ignored_start_dones", done_cnt - dbase, 1);
    check("ignored_start_idle", int'(busy), 0);

    // Reset after the second valid of a full run, with start held high.
    @(negedge clk);
    #1;
    base = nvalid_total;
    push_model(11, 5, 8'hFF, 1'b0);
    drive_start(5'd11, 5'd5, 8'hFF, 1'b0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    #1;
    while ((nvalid_total - base) < 2 && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("second_valid_seen", nvalid_total - base, 2);
    reset = 1'b1;
    start = 1'b1;
    sb.delete();
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    start = 1'b0;
    run_seq(vecs[8], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
